// File: rtl/ring_meter_pkg.sv
// Shared register map, bit positions and FSM encoding for the ring frequency meter.
package ring_meter_pkg;

    localparam logic [7:0] ADDR_CONTROL     = 8'h00;
    localparam logic [7:0] ADDR_STATUS      = 8'h04;
    localparam logic [7:0] ADDR_WINDOW      = 8'h08;
    localparam logic [7:0] ADDR_RESULT_BASE = 8'h10;
    localparam logic [7:0] ADDR_TRIM_BASE   = 8'h40;

    localparam int CTRL_START          = 0;
    localparam int CTRL_CONT           = 1;
    localparam int CTRL_IRQ_EN         = 3;
    localparam int CTRL_ABORT          = 4;
    localparam int CTRL_CLKMUX_LSB     = 8;
    localparam int CTRL_RING_START_LSB = 16;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_OVF_LSB = 8;

    localparam int SETTLE_CYCLES = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COUNT  = 2'd2,
        LATCH  = 2'd3
    } meter_state_e;

endpackage

// File: rtl/ring_edge_counter.sv
// One measurement channel: 2-FF synchronizer plus delay flop, rising-edge
// detect and a saturating edge counter with an overflow pulse.
module ring_edge_counter #(
    parameter int COUNT_BITS = 24
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic                  ring_i,
    input  logic                  clr_i,
    input  logic                  en_i,
    output logic [COUNT_BITS-1:0] count_o,
    output logic                  ovf_o
);

    logic [2:0]            sync_q;
    logic [COUNT_BITS-1:0] count_q;
    logic [COUNT_BITS-1:0] count_d;
    logic                  edge_w;
    logic                  sat_w;

    assign edge_w = sync_q[1] & ~sync_q[2];
    assign sat_w  = &count_q;
    assign ovf_o  = en_i & ~clr_i & edge_w & sat_w;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && edge_w && !sat_w) begin
            count_d = count_q + COUNT_BITS'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sync_q  <= '0;
            count_q <= '0;
        end else begin
            sync_q  <= {sync_q[1:0], ring_i};
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ring_freq_meter.sv
// Multi-channel ring oscillator frequency meter with a Wishbone slave:
// gated edge counting over a programmable window, atomic result latch, irq.
module ring_freq_meter
    import ring_meter_pkg::*;
#(
    parameter int NUM_RINGS   = 4,
    parameter int TRIM_BITS   = 28,
    parameter int CLKMUX_BITS = 3,
    parameter int COUNT_BITS  = 24,
    parameter int WINDOW_BITS = 24
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    input  logic                           wb_stb_i,
    input  logic                           wb_cyc_i,
    input  logic                           wb_we_i,
    input  logic [3:0]                     wb_sel_i,
    input  logic [31:0]                    wb_adr_i,
    input  logic [31:0]                    wb_dat_i,
    output logic                           wb_ack_o,
    output logic [31:0]                    wb_dat_o,
    input  logic [NUM_RINGS-1:0]           ring_in,
    output logic [NUM_RINGS-1:0]           ring_start,
    output logic [NUM_RINGS*TRIM_BITS-1:0] ring_trim,
    output logic [CLKMUX_BITS-1:0]         ring_clkmux,
    output logic                           irq_o
);

    logic                   ack_q;
    logic [31:0]            rd_data_q;
    logic [31:0]            rd_data_d;
    logic                   cont_q;
    logic                   irq_en_q;
    logic [CLKMUX_BITS-1:0] clkmux_q;
    logic [NUM_RINGS-1:0]   ring_start_q;
    logic [WINDOW_BITS-1:0] window_q;
    logic [TRIM_BITS-1:0]   trim_q   [NUM_RINGS];
    logic [COUNT_BITS-1:0]  result_q [NUM_RINGS];
    logic                   done_q;
    logic                   done_d;
    logic [NUM_RINGS-1:0]   ovf_q;
    logic [NUM_RINGS-1:0]   ovf_d;
    logic                   irq_q;

    meter_state_e           state_q;
    meter_state_e           state_d;
    logic [1:0]             settle_q;
    logic [1:0]             settle_d;
    logic [WINDOW_BITS-1:0] win_cnt_q;
    logic [WINDOW_BITS-1:0] win_cnt_d;

    logic [COUNT_BITS-1:0]  count_w [NUM_RINGS];
    logic [NUM_RINGS-1:0]   ovf_w;

    logic       wb_req;
    logic       wr_en;
    logic [7:0] adr8;
    logic       wr_ctrl;
    logic       wr_status;
    logic       start_req;
    logic       abort_req;
    logic       latch_en;
    logic       unused_bits;

    assign adr8      = wb_adr_i[7:0];
    assign wb_req    = wb_stb_i & wb_cyc_i & ~ack_q;
    assign wr_en     = wb_req & wb_we_i & (|wb_sel_i);
    assign wr_ctrl   = wr_en && (adr8 == ADDR_CONTROL);
    assign wr_status = wr_en && (adr8 == ADDR_STATUS);
    assign start_req = wr_ctrl & wb_dat_i[CTRL_START];
    assign abort_req = wr_ctrl & wb_dat_i[CTRL_ABORT];
    // An abort landing on the LATCH cycle also suppresses the latch.
    assign latch_en  = (state_q == LATCH) && !abort_req;
    assign unused_bits = ^{wb_adr_i[31:8], wb_dat_i};

    generate
        for (genvar gi = 0; gi < NUM_RINGS; gi++) begin : g_ring
            ring_edge_counter #(
                .COUNT_BITS (COUNT_BITS)
            ) u_edge_counter (
                .clk_i   (wb_clk_i),
                .srst_i  (wb_rst_i),
                .ring_i  (ring_in[gi]),
                .clr_i   (state_q == SETTLE),
                .en_i    (state_q == COUNT),
                .count_o (count_w[gi]),
                .ovf_o   (ovf_w[gi])
            );
            assign ring_trim[gi*TRIM_BITS +: TRIM_BITS] = trim_q[gi];
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        win_cnt_d = win_cnt_q;
        case (state_q)
            IDLE: begin
                settle_d = '0;
                if (start_req) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // WINDOW is sampled here, so mid-run writes apply to the next run.
                win_cnt_d = window_q;
                if (settle_q == 2'(SETTLE_CYCLES - 1)) begin
                    settle_d = '0;
                    state_d  = (window_q == '0) ? LATCH : COUNT;
                end else begin
                    settle_d = settle_q + 2'd1;
                end
            end
            COUNT: begin
                if (win_cnt_q == WINDOW_BITS'(1)) begin
                    state_d = LATCH;
                end else begin
                    win_cnt_d = win_cnt_q - WINDOW_BITS'(1);
                end
            end
            LATCH: begin
                state_d = cont_q ? SETTLE : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort_req) begin
            state_d  = IDLE;
            settle_d = '0;
        end
    end

    always_comb begin
        done_d = done_q;
        ovf_d  = ovf_q;
        if (wr_status) begin
            done_d = done_q & ~wb_dat_i[STAT_DONE];
            ovf_d  = ovf_q & ~wb_dat_i[STAT_OVF_LSB +: NUM_RINGS];
        end
        done_d = done_d | latch_en;
        ovf_d  = ovf_d | ovf_w;
    end

    always_comb begin
        rd_data_d = '0;
        if (adr8 == ADDR_CONTROL) begin
            rd_data_d[CTRL_CONT]   = cont_q;
            rd_data_d[CTRL_IRQ_EN] = irq_en_q;
            rd_data_d[CTRL_CLKMUX_LSB +: CLKMUX_BITS]   = clkmux_q;
            rd_data_d[CTRL_RING_START_LSB +: NUM_RINGS] = ring_start_q;
        end else if (adr8 == ADDR_STATUS) begin
            rd_data_d[STAT_BUSY] = (state_q != IDLE);
            rd_data_d[STAT_DONE] = done_q;
            rd_data_d[STAT_OVF_LSB +: NUM_RINGS] = ovf_q;
        end else if (adr8 == ADDR_WINDOW) begin
            rd_data_d = 32'(window_q);
        end
        for (int i = 0; i < NUM_RINGS; i++) begin
            if (adr8 == ADDR_RESULT_BASE + 8'(4 * i)) begin
                rd_data_d = 32'(result_q[i]);
            end
            if (adr8 == ADDR_TRIM_BASE + 8'(4 * i)) begin
                rd_data_d = 32'(trim_q[i]);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q        <= 1'b0;
            rd_data_q    <= '0;
            cont_q       <= 1'b0;
            irq_en_q     <= 1'b0;
            clkmux_q     <= '0;
            ring_start_q <= '0;
            window_q     <= '0;
            done_q       <= 1'b0;
            ovf_q        <= '0;
            irq_q        <= 1'b0;
            state_q      <= IDLE;
            settle_q     <= '0;
            win_cnt_q    <= '0;
            for (int i = 0; i < NUM_RINGS; i++) begin
                trim_q[i]   <= '0;
                result_q[i] <= '0;
            end
        end else begin
            ack_q     <= wb_req;
            state_q   <= state_d;
            settle_q  <= settle_d;
            win_cnt_q <= win_cnt_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            irq_q     <= irq_en_q & done_q;
            if (wb_req) begin
                rd_data_q <= rd_data_d;
            end
            if (wr_ctrl) begin
                cont_q       <= wb_dat_i[CTRL_CONT];
                irq_en_q     <= wb_dat_i[CTRL_IRQ_EN];
                clkmux_q     <= wb_dat_i[CTRL_CLKMUX_LSB +: CLKMUX_BITS];
                ring_start_q <= wb_dat_i[CTRL_RING_START_LSB +: NUM_RINGS];
            end
            if (wr_en && (adr8 == ADDR_WINDOW)) begin
                window_q <= wb_dat_i[WINDOW_BITS-1:0];
            end
            for (int i = 0; i < NUM_RINGS; i++) begin
                if (wr_en && (adr8 == ADDR_TRIM_BASE + 8'(4 * i))) begin
                    trim_q[i] <= wb_dat_i[TRIM_BITS-1:0];
                end
                if (latch_en) begin
                    result_q[i] <= count_w[i];
                end
            end
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_dat_o    = rd_data_q;
    assign ring_start  = ring_start_q;
    assign ring_clkmux = clkmux_q;
    assign irq_o       = irq_q;

endmodule

// File: doc/ring_freq_meter.md
Name: ring_freq_meter

Overview:
Multi-channel successor to the single-ring controller, with a Wishbone slave for control, per-ring trim and clock mux, and a gated frequency measurement.
- Counts rising edges of NUM_RINGS (divided) ring outputs over a programmable window of wb_clk_i cycles.
- Latches the results atomically and raises done/irq.
- Each ring input passes through a proper synchronizer, replacing the unsynchronized cross-clock count of the previous generation.

Parameters:
NUM_RINGS, 4, number of ring channels (1..8)
TRIM_BITS, 28, trim word width per ring
CLKMUX_BITS, 3, ring clock mux/divider select width
COUNT_BITS, 24, edge counter width per channel (<=32)
WINDOW_BITS, 24, measurement window length width (<=32)

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  reset, synchronous, active-high
wb_stb_i, wb_cyc_i, wb_we_i  in  1 each  Wishbone strobe/cycle/write
wb_sel_i  in  4  byte selects (any set = write)
wb_adr_i  in  32  address, only [7:0] decoded
wb_dat_i  in  32  write data
wb_ack_o  out  1  ack
wb_dat_o  out  32  read data
ring_in  in  NUM_RINGS  async ring outputs (post-divider)
ring_start  out  NUM_RINGS  per-ring enable
ring_trim  out  NUM_RINGS*TRIM_BITS  flattened trim, ring i at [i*TRIM_BITS +: TRIM_BITS]
ring_clkmux  out  CLKMUX_BITS  divider select
irq_o  out  1  measurement-complete interrupt

Behaviour:
- Reset (wb_rst_i high at a clock edge) clears all of the following to 0: outputs, CSRs, counters and results. FSM goes to IDLE. Reset mid-measurement discards it.
- Wishbone transfers:
  - When stb&cyc&!ack, ack=1 the next cycle, for one cycle only; back-to-back transfers take 2 cycles each.
  - Read data is registered and valid with ack. Unmapped reads return 0; unmapped writes are ignored.
- Register map:
  - 0x00 CONTROL (RW, but bit0 and bit4 read 0):
    - bit0 START (self-clearing pulse)
    - bit1 CONT (continuous)
    - bit3 IRQ_EN
    - bit4 ABORT (self-clearing)
    - [CLKMUX_BITS+7:8] clkmux
    - [NUM_RINGS+15:16] ring_start
  - 0x04 STATUS:
    - bit0 BUSY (RO)
    - bit1 DONE (W1C)
    - [NUM_RINGS+7:8] per-channel OVF (sticky, W1C)
  - 0x08 WINDOW (RW, [WINDOW_BITS-1:0]).
  - 0x10+4*i RESULT[i] (RO, zero-extended).
  - 0x40+4*i TRIM[i] (RW).
- Edge path per channel: 2-FF synchronizer plus a delay flop; edge = s2 & ~s3. Only ring_in frequencies below wb_clk_i/2 are guaranteed correct.
- FSM IDLE -> SETTLE -> COUNT -> LATCH:
  - IDLE: START write -> SETTLE. START while BUSY is ignored.
  - SETTLE, exactly 3 cycles (synchronizer flush): clear counters, load window counter from WINDOW. WINDOW changes during a run take effect at the next SETTLE.
  - COUNT: counters increment on edge; window counter decrements each cycle; exit when it reaches 1, so counting lasts exactly WINDOW cycles. WINDOW=0 skips COUNT (results 0).
  - LATCH, 1 cycle: RESULT[i] <= count[i]; DONE <= 1. Then SETTLE if CONT, else IDLE.
- BUSY = state != IDLE.
- Counters saturate at all-ones. An edge while saturated sets OVF[i]; OVF is not cleared by a new run.
- ABORT in any state -> IDLE next cycle, with no LATCH and no DONE. ABORT beats START when both are written in the same write.
- Clearing CONT during a run lets the current window finish and latch, then IDLE.
- Same cycle DONE set by LATCH and W1C on DONE: set wins. The same rule applies to OVF.
- irq_o = IRQ_EN & DONE, registered (1 cycle after DONE rises).
- RESULT is read while stable; an update only occurs in LATCH. A read coinciding with LATCH returns the old value.

Decomposition:
- Package ring_meter_pkg: register offsets (CONTROL/STATUS/WINDOW/RESULT_BASE/TRIM_BASE), CONTROL/STATUS bit indices, FSM state enum {IDLE,SETTLE,COUNT,LATCH}, SETTLE_CYCLES=3.
- Sub-module ring_edge_counter (synchronizer, edge detect, saturating counter, ovf pulse; inputs clr/en), instantiated NUM_RINGS times via generate.

Test Plan:
- Reset then read all regs -> 0x0; ring_start=0, ring_trim=0, irq_o=0; write TRIM[2]=0x0ABCDEF -> ring_trim[2] slice=0x0ABCDEF, readback matches.
- WINDOW=1000, ring_in[0] square wave period 10 clks, START -> BUSY 1..1004 cycles later DONE=1, RESULT[0]=100 (+/-1), other channels 0.
- COUNT_BITS=8, ring_in period 4, WINDOW=2000 -> RESULT=255, OVF[ch]=1; W1C 0x100 clears it.
- CONT=1, IRQ_EN=1, WINDOW=50 -> DONE/irq every 54 cycles; clear CONT mid-window -> one more latch, then BUSY=0.
- ABORT written 20 cycles into a WINDOW=500 run -> BUSY=0 next cycle, DONE stays 0, RESULT unchanged.
- wb_rst_i pulse mid-COUNT -> all state 0; START while BUSY ignored (window not restarted); WINDOW=0 -> DONE after 4 cycles, RESULT=0.
